pmf_reservation_station: RTL and testbench

// - Reservation station in front of the pmfState/pmfALU pair: holds issued add/sub/and/or ops until both operands
//   are valid, then dispatches one op per accepted handshake into the ALU.
// - Snoops the common data bus (CDB) to capture pending operands; frees an entry only when its own result label is

---
 rtl/pmf_reservation_station.sv | 221 ++++++++++++++++++++++
 tb/tb_pmf_reservation_station.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmf_reservation_station.sv
// rtl/pmf_reservation_station.sv - reservation station in front of pmfState/pmfALU; optional macro RS_AGE_ORDER_EN
module pmf_reservation_station #(
    parameter int         DEPTH      = 3,
    parameter logic [3:0] BASE_LABEL = 4'd1
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        issueValid,
    input  logic [1:0]  issueOp,
    input  logic [31:0] issueVj,
    input  logic [3:0]  issueQj,
    input  logic [31:0] issueVk,
    input  logic [3:0]  issueQk,
    output logic        issueReady,
    output logic [3:0]  issueLabel,
    input  logic        cdbValid,
    input  logic [3:0]  cdbLabel,
    input  logic [31:0] cdbData,
    input  logic        aluAvailable,
    output logic        aluWEN,
    output logic [1:0]  aluOp,
    output logic [31:0] aluData1,
    output logic [31:0] aluData2,
    output logic [3:0]  aluLabel,
    output logic [3:0]  busyCount
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} ent_state_t;

    ent_state_t  state_q [DEPTH];
    ent_state_t  state_d [DEPTH];
    logic [1:0]  op_q    [DEPTH];
    logic [1:0]  op_d    [DEPTH];
    logic [31:0] vj_q    [DEPTH];
    logic [31:0] vj_d    [DEPTH];
    logic [31:0] vk_q    [DEPTH];
    logic [31:0] vk_d    [DEPTH];
    logic [3:0]  qj_q    [DEPTH];
    logic [3:0]  qj_d    [DEPTH];
    logic [3:0]  qk_q    [DEPTH];
    logic [3:0]  qk_d    [DEPTH];
`ifdef RS_AGE_ORDER_EN
    logic [3:0]  age_q   [DEPTH];
    logic [3:0]  age_d   [DEPTH];
    logic [3:0]  sel_age;
    logic        rel_found;
    logic [3:0]  rel_age;
`endif

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [3:0]    busy_cnt;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          issue_fire;
    logic          dispatch_fire;
    logic          byp_j;
    logic          byp_k;
    logic [31:0]   new_vj;
    logic [31:0]   new_vk;
    logic [3:0]    new_qj;
    logic [3:0]    new_qk;

    // Lowest-index free entry and occupancy, both from registered state only
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        busy_cnt   = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] == ST_FREE) begin
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IW'(i);
                end
            end else begin
                busy_cnt = busy_cnt + 4'd1;
            end
        end
    end

    // Pick the READY entry presented to the ALU: oldest when age ordering is built in, else lowest index
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
        sel_age   = 4'hF;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] == ST_READY) begin
`ifdef RS_AGE_ORDER_EN
                if (!sel_found || (age_q[i] < sel_age)) begin
                    sel_found = 1'b1;
                    sel_idx   = IW'(i);
                    sel_age   = age_q[i];
                end
`else
                if (!sel_found) begin
                    sel_found = 1'b1;
                    sel_idx   = IW'(i);
                end
`endif
            end
        end
    end

    assign issueReady = free_found;
    assign issueLabel = BASE_LABEL + 4'(free_idx);
    assign busyCount  = busy_cnt;
    assign aluWEN     = sel_found;
    assign aluOp      = sel_found ? op_q[sel_idx] : 2'd0;
    assign aluData1   = sel_found ? vj_q[sel_idx] : 32'd0;
    assign aluData2   = sel_found ? vk_q[sel_idx] : 32'd0;
    assign aluLabel   = sel_found ? BASE_LABEL + 4'(sel_idx) : 4'd0;

    assign issue_fire    = issueValid && free_found;
    assign dispatch_fire = sel_found && aluAvailable;

    // An operand whose producer broadcasts in the issue cycle is taken from the CDB, not left waiting on a stale tag
    assign byp_j  = cdbValid && (issueQj != 4'd0) && (cdbLabel == issueQj);
    assign byp_k  = cdbValid && (issueQk != 4'd0) && (cdbLabel == issueQk);
    assign new_vj = byp_j ? cdbData : issueVj;
    assign new_vk = byp_k ? cdbData : issueVk;
    assign new_qj = byp_j ? 4'd0 : issueQj;
    assign new_qk = byp_k ? 4'd0 : issueQk;

    // Per-entry next state: issue, CDB capture, WAIT->READY promotion, dispatch and release on own-tag broadcast
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
        end
`ifdef RS_AGE_ORDER_EN
        rel_found = 1'b0;
        rel_age   = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if ((state_q[i] == ST_EXEC) && cdbValid && (cdbLabel != 4'd0) &&
                (cdbLabel == BASE_LABEL + 4'(i))) begin
                rel_found = 1'b1;
                rel_age   = age_q[i];
            end
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != ST_FREE) begin
                if (cdbValid && (cdbLabel != 4'd0) && (qj_q[i] == cdbLabel)) begin
                    vj_d[i] = cdbData;
                    qj_d[i] = 4'd0;
                end
                if (cdbValid && (cdbLabel != 4'd0) && (qk_q[i] == cdbLabel)) begin
                    vk_d[i] = cdbData;
                    qk_d[i] = 4'd0;
                end
            end
            case (state_q[i])
                ST_FREE: begin
                    if (issue_fire && (free_idx == IW'(i))) begin
                        op_d[i]    = issueOp;
                        vj_d[i]    = new_vj;
                        vk_d[i]    = new_vk;
                        qj_d[i]    = new_qj;
                        qk_d[i]    = new_qk;
                        state_d[i] = ((new_qj == 4'd0) && (new_qk == 4'd0)) ? ST_READY : ST_WAIT;
`ifdef RS_AGE_ORDER_EN
                        age_d[i]   = busy_cnt - (rel_found ? 4'd1 : 4'd0);
`endif
                    end
                end
                ST_WAIT: begin
                    if ((qj_d[i] == 4'd0) && (qk_d[i] == 4'd0)) state_d[i] = ST_READY;
                end
                ST_READY: begin
                    if (dispatch_fire && (sel_idx == IW'(i))) state_d[i] = ST_EXEC;
                end
                ST_EXEC: begin
                    if (cdbValid && (cdbLabel != 4'd0) && (cdbLabel == BASE_LABEL + 4'(i)))
                        state_d[i] = ST_FREE;
                end
                default: state_d[i] = ST_FREE;
            endcase
`ifdef RS_AGE_ORDER_EN
            if ((state_q[i] != ST_FREE) && rel_found && (age_q[i] > rel_age))
                age_d[i] = age_q[i] - 4'd1;
`endif
        end
    end

    // Entry storage; reset drops every entry regardless of its state
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                op_q[i]    <= 2'd0;
                vj_q[i]    <= 32'd0;
                vk_q[i]    <= 32'd0;
                qj_q[i]    <= 4'd0;
                qk_q[i]    <= 4'd0;
`ifdef RS_AGE_ORDER_EN
                age_q[i]   <= 4'd0;
`endif
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                op_q[i]    <= op_d[i];
                vj_q[i]    <= vj_d[i];
                vk_q[i]    <= vk_d[i];
                qj_q[i]    <= qj_d[i];
                qk_q[i]    <= qk_d[i];
`ifdef RS_AGE_ORDER_EN
                age_q[i]   <= age_d[i];
`endif
            end
        end
    end
endmodule

// File: tb/tb_pmf_reservation_station.sv
// tb/tb_pmf_reservation_station.sv - directed scoreboard bench for pmf_reservation_station
module tb_pmf_reservation_station;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    logic        clk = 1'b0;
    logic        nRST;
    logic        issueValid;
    logic [1:0]  issueOp;
    logic [31:0] issueVj;
    logic [3:0]  issueQj;
    logic [31:0] issueVk;
    logic [3:0]  issueQk;
    logic        issueReady;
    logic [3:0]  issueLabel;
    logic        cdbValid;
    logic [3:0]  cdbLabel;
    logic [31:0] cdbData;
    logic        aluAvailable;
    logic        aluWEN;
    logic [1:0]  aluOp;
    logic [31:0] aluData1;
    logic [31:0] aluData2;
    logic [3:0]  aluLabel;
    logic [3:0]  busyCount;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  label;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pmf_reservation_station #(.DEPTH(3), .BASE_LABEL(4'd1)) dut (
        .clk(clk), .nRST(nRST),
        .issueValid(issueValid), .issueOp(issueOp), .issueVj(issueVj), .issueQj(issueQj),
        .issueVk(issueVk), .issueQk(issueQk), .issueReady(issueReady), .issueLabel(issueLabel),
        .cdbValid(cdbValid), .cdbLabel(cdbLabel), .cdbData(cdbData),
        .aluAvailable(aluAvailable), .aluWEN(aluWEN), .aluOp(aluOp), .aluData1(aluData1),
        .aluData2(aluData2), .aluLabel(aluLabel), .busyCount(busyCount)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk);
        issueValid = 1'b1;
        issueOp    = op;
        issueVj    = vj;
        issueQj    = qj;
        issueVk    = vk;
        issueQk    = qk;
        tick();
        issueValid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] label, input logic [31:0] data);
        cdbValid = 1'b1;
        cdbLabel = label;
        cdbData  = data;
        tick();
        cdbValid = 1'b0;
        cdbLabel = 4'd0;
        cdbData  = 32'd0;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] label, input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        e.op = op; e.label = label; e.d1 = d1; e.d2 = d2;
        exp_q.push_back(e);
    endtask

    task automatic check_front(input string tag);
        exp_t e;
        chk({tag, "_wen"}, 70'(aluWEN), 70'(1'b1));
        chk({tag, "_queue_nonempty"}, 70'(exp_q.size() != 0), 70'(1'b1));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk(tag, {aluOp, aluLabel, aluData1, aluData2}, e);
        end
    endtask

    task automatic expect_dispatch(input string tag);
        int n = 0;
        while (aluWEN !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_front(tag);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        aluAvailable = 1'b1;
        tick();
        aluAvailable = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; issueValid = 1'b0; issueOp = 2'd0; issueVj = 32'd0; issueQj = 4'd0;
        issueVk = 32'd0; issueQk = 4'd0; cdbValid = 1'b0; cdbLabel = 4'd0; cdbData = 32'd0;
        aluAvailable = 1'b0;
        tick();
        tick();
        chk("rst_issueReady", 70'(issueReady), 70'(1'b1));
        chk("rst_issueLabel", 70'(issueLabel), 70'(4'd1));
        chk("rst_busyCount", 70'(busyCount), 70'(4'd0));
        chk("rst_alu", {aluWEN, aluOp, aluLabel, aluData1, aluData2}, 70'd0);
        nRST = 1'b1;
        tick();

        // Ready-on-issue op dispatches the next cycle and frees on its own broadcast
        aluAvailable = 1'b1;
        issue(OP_ADD, 32'd5, 4'd0, 32'd7, 4'd0);
        aluAvailable = 1'b0;
        push(OP_ADD, 4'd1, 32'd5, 32'd7);
        chk("add_busy1", 70'(busyCount), 70'(4'd1));
        expect_dispatch("add_dispatch");
        chk("add_exec_wen", 70'(aluWEN), 70'(1'b0));
        chk("add_exec_busy", 70'(busyCount), 70'(4'd1));
        cdb(4'd1, 32'd12);
        chk("add_freed_busy", 70'(busyCount), 70'(4'd0));
        chk("add_freed_label", 70'(issueLabel), 70'(4'd1));

        // Operand captured from CDB after issue
        issue(OP_SUB, 32'd0, 4'd9, 32'd3, 4'd0);
        chk("sub_wait_wen", 70'(aluWEN), 70'(1'b0));
        chk("sub_wait_busy", 70'(busyCount), 70'(4'd1));
        cdb(4'd15, 32'd99);
        chk("foreign_tag_wen", 70'(aluWEN), 70'(1'b0));
        cdb(4'd9, 32'd10);
        push(OP_SUB, 4'd1, 32'd10, 32'd3);
        expect_dispatch("sub_dispatch");
        cdb(4'd0, 32'd0);
        chk("label0_no_free", 70'(busyCount), 70'(4'd1));
        cdb(4'd1, 32'd0);
        chk("sub_freed_busy", 70'(busyCount), 70'(4'd0));

        // Issue-cycle bypass from the CDB
        cdbValid = 1'b1; cdbLabel = 4'd9; cdbData = 32'd42;
        issue(OP_OR, 32'd99, 4'd9, 32'd8, 4'd0);
        cdbValid = 1'b0; cdbLabel = 4'd0; cdbData = 32'd0;
        chk("bypass_ready", 70'(aluWEN), 70'(1'b1));
        push(OP_OR, 4'd1, 32'd42, 32'd8);
        expect_dispatch("bypass_dispatch");
        cdb(4'd1, 32'd0);

        // Fill, overflow ignored, free of tag 2 not reusable in the same cycle
        issue(OP_AND, 32'd0, 4'd9, 32'd11, 4'd0);
        issue(OP_AND, 32'd0, 4'd9, 32'd22, 4'd0);
        issue(OP_AND, 32'd0, 4'd9, 32'd33, 4'd0);
        chk("full_ready", 70'(issueReady), 70'(1'b0));
        chk("full_busy", 70'(busyCount), 70'(4'd3));
        issue(OP_ADD, 32'd1, 4'd0, 32'd1, 4'd0);
        chk("full_ignored_busy", 70'(busyCount), 70'(4'd3));
        chk("full_ignored_ready", 70'(issueReady), 70'(1'b0));
        cdb(4'd9, 32'd77);
        push(OP_AND, 4'd1, 32'd77, 32'd11);
        push(OP_AND, 4'd2, 32'd77, 32'd22);
        push(OP_AND, 4'd3, 32'd77, 32'd33);
        expect_dispatch("fill_d1");
        expect_dispatch("fill_d2");
        issueValid = 1'b1; issueOp = OP_ADD; issueVj = 32'd1; issueQj = 4'd0; issueVk = 32'd1; issueQk = 4'd0;
        cdb(4'd2, 32'd0);
        issueValid = 1'b0;
        chk("free2_busy", 70'(busyCount), 70'(4'd2));
        chk("free2_ready", 70'(issueReady), 70'(1'b1));
        chk("free2_label", 70'(issueLabel), 70'(4'd2));
        expect_dispatch("fill_d3");
        cdb(4'd1, 32'd0);
        cdb(4'd3, 32'd0);
        chk("fill_drained", 70'(busyCount), 70'(4'd0));

        // Issue order 3,1,2 then release all at once
        issue(OP_ADD, 32'd1, 4'd0, 32'd1, 4'd0);
        issue(OP_ADD, 32'd2, 4'd0, 32'd2, 4'd0);
        issue(OP_ADD, 32'd3, 4'd0, 32'd3, 4'd0);
        push(OP_ADD, 4'd1, 32'd1, 32'd1);
        push(OP_ADD, 4'd2, 32'd2, 32'd2);
        push(OP_ADD, 4'd3, 32'd3, 32'd3);
        expect_dispatch("pre_d1");
        expect_dispatch("pre_d2");
        expect_dispatch("pre_d3");
        cdb(4'd3, 32'd0);
        chk("age_label3", 70'(issueLabel), 70'(4'd3));
        issue(OP_OR, 32'd100, 4'd9, 32'd1, 4'd0);
        cdb(4'd1, 32'd0);
        chk("age_label1", 70'(issueLabel), 70'(4'd1));
        issue(OP_AND, 32'd200, 4'd9, 32'd2, 4'd0);
        cdb(4'd2, 32'd0);
        chk("age_label2", 70'(issueLabel), 70'(4'd2));
        issue(OP_SUB, 32'd300, 4'd9, 32'd3, 4'd0);
        chk("age_wait_wen", 70'(aluWEN), 70'(1'b0));
        cdb(4'd9, 32'd50);
`ifdef RS_AGE_ORDER_EN
        push(OP_OR,  4'd3, 32'd50, 32'd1);
        push(OP_AND, 4'd1, 32'd50, 32'd2);
        push(OP_SUB, 4'd2, 32'd50, 32'd3);
`else
        push(OP_AND, 4'd1, 32'd50, 32'd2);
        push(OP_SUB, 4'd2, 32'd50, 32'd3);
        push(OP_OR,  4'd3, 32'd50, 32'd1);
`endif
        check_front("hold_before");
        tick();
        tick();
        check_front("hold_after");
        expect_dispatch("order_1");
        expect_dispatch("order_2");
        expect_dispatch("order_3");
        cdb(4'd1, 32'd0);
        cdb(4'd2, 32'd0);
        cdb(4'd3, 32'd0);
        chk("order_drained", 70'(busyCount), 70'(4'd0));

        // Asynchronous reset with one EXEC and one WAIT entry
        issue(OP_ADD, 32'd4, 4'd0, 32'd6, 4'd0);
        push(OP_ADD, 4'd1, 32'd4, 32'd6);
        expect_dispatch("pre_reset_dispatch");
        issue(OP_SUB, 32'd0, 4'd9, 32'd1, 4'd0);
        chk("pre_reset_busy", 70'(busyCount), 70'(4'd2));
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_busy", 70'(busyCount), 70'(4'd0));
        chk("mid_rst_issue", {issueReady, issueLabel}, {1'b1, 4'd1});
        chk("mid_rst_alu", {aluWEN, aluOp, aluLabel, aluData1, aluData2}, 70'd0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        tick();
        cdb(4'd1, 32'd5);
        cdb(4'd9, 32'd5);
        chk("post_rst_busy", 70'(busyCount), 70'(4'd0));
        chk("post_rst_wen", 70'(aluWEN), 70'(1'b0));
        issue(OP_OR, 32'hA, 4'd0, 32'hB, 4'd0);
        push(OP_OR, 4'd1, 32'hA, 32'hB);
        expect_dispatch("post_rst_dispatch");
        cdb(4'd1, 32'd0);
        chk("final_busy", 70'(busyCount), 70'(4'd0));
        chk("queue_empty", 70'(exp_q.size()), 70'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
